fmab_norm: RTL and testbench

FMAB_NORM -- requirements
Module: fmab_norm

---
 rtl/fmab_pkg.sv | 13 +
 rtl/fmab_norm_lane.sv | 67 ++++++
 rtl/fmab_norm.sv | 96 +++++++++
 tb/tb_fmab_norm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fmab_pkg.sv
// Shared constants and FSM encoding for the four-lane accumulator to binary32 normaliser.
// No logic here; imported by fmab_norm and fmab_norm_lane.
package fmab_pkg;
  localparam int LANES       = 4;
  localparam int ACC_W_DEF   = 32;
  localparam int EXP_W_DEF   = 10;
  localparam int EXP_OFFSET  = 141;
  localparam int F32_EXP_W   = 8;
  localparam int F32_MAN_W   = 23;
  localparam int F32_EXP_MAX = 255;

  typedef enum logic [1:0] {ST_IDLE, ST_NORM, ST_SEND} state_t;
endpackage

// File: rtl/fmab_norm_lane.sv
// Combinational single-lane converter: signed acc x 2^(exp-268) to binary32, flush-to-zero, saturate to inf.
// Rounds to nearest even when FMAB_NORM_RNE_EN is defined, otherwise truncates toward zero.
module fmab_norm_lane
  import fmab_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [EXP_W-1:0] expo,
  output logic [31:0]      result
);
  localparam int PW   = $clog2(ACC_W);
  localparam int EW   = EXP_W + 3;
  localparam int MW1  = F32_MAN_W + 1;
  localparam int DROP = ACC_W - 1 - F32_MAN_W;

  logic                 sign;
  logic [ACC_W-1:0]     mag;
  logic [ACC_W-1:0]     norm;
  logic [PW-1:0]        p;
  logic [F32_MAN_W-1:0] mant;
  logic                 round_up;
  logic [MW1-1:0]       mant_r;
  logic [EW-1:0]        e_raw;
  logic [EW-1:0]        e_fin;
`ifdef FMAB_NORM_RNE_EN
  logic                 guard;
  logic                 sticky;
`endif

  always_comb begin
    sign = acc[ACC_W-1];
    // Unsigned magnitude: the most negative input maps to 2^(ACC_W-1), which still fits.
    mag  = sign ? (~acc + ACC_W'(1)) : acc;

    p = '0;
    for (int i = 0; i < ACC_W; i++) begin
      if (mag[i]) p = PW'(i);
    end

    norm  = mag << (PW'(ACC_W - 1) - p);
    mant  = F32_MAN_W'(norm >> DROP);
    e_raw = EW'(p) + EW'(expo) - EW'(EXP_OFFSET);

`ifdef FMAB_NORM_RNE_EN
    guard    = norm[DROP-1];
    sticky   = |norm[DROP-2:0];
    round_up = guard & (sticky | mant[0]);
`else
    round_up = 1'b0;
`endif

    // A carry out of the mantissa leaves the fraction zero and bumps the exponent.
    mant_r = {1'b0, mant} + MW1'(round_up);
    e_fin  = e_raw + EW'(mant_r[F32_MAN_W]);

    if (acc == '0 || expo == '0)
      result = '0;
    else if (e_fin[EW-1] || e_fin == '0)
      result = {sign, 31'b0};
    else if (e_fin >= EW'(F32_EXP_MAX))
      result = {sign, {F32_EXP_W{1'b1}}, {F32_MAN_W{1'b0}}};
    else
      result = {sign, e_fin[F32_EXP_W-1:0], mant_r[F32_MAN_W-1:0]};
  end
endmodule

// File: rtl/fmab_norm.sv
// Snapshots four lane accumulators on start and streams them out as binary32 over valid/ready.
// Two cycles per lane with ready held high; out_data/out_lane hold while out_valid & !out_ready.
module fmab_norm
  import fmab_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [ACC_W-1:0] acc0,
  input  logic [ACC_W-1:0] acc1,
  input  logic [ACC_W-1:0] acc2,
  input  logic [ACC_W-1:0] acc3,
  input  logic [EXP_W-1:0] exp0,
  input  logic [EXP_W-1:0] exp1,
  input  logic [EXP_W-1:0] exp2,
  input  logic [EXP_W-1:0] exp3,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [1:0]       out_lane,
  output logic             done
);
  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt;
  logic [ACC_W-1:0] acc_snap [LANES];
  logic [EXP_W-1:0] exp_snap [LANES];
  logic [31:0]      lane_res;
  logic             last_accept;

  fmab_norm_lane #(.ACC_W(ACC_W), .EXP_W(EXP_W)) u_lane (
    .acc    (acc_snap[cnt]),
    .expo   (exp_snap[cnt]),
    .result (lane_res)
  );

  assign last_accept = (state == ST_SEND) && out_ready && (cnt == 2'(LANES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_NORM;
      ST_NORM: state_nxt = ST_SEND;
      ST_SEND: if (out_ready) state_nxt = (cnt == 2'(LANES - 1)) ? ST_IDLE : ST_NORM;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      out_data <= '0;
      out_lane <= '0;
      done     <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        acc_snap[i] <= '0;
        exp_snap[i] <= '0;
      end
    end else begin
      done <= last_accept;
      case (state)
        ST_IDLE: if (start) begin
          acc_snap[0] <= acc0;
          acc_snap[1] <= acc1;
          acc_snap[2] <= acc2;
          acc_snap[3] <= acc3;
          exp_snap[0] <= exp0;
          exp_snap[1] <= exp1;
          exp_snap[2] <= exp2;
          exp_snap[3] <= exp3;
          cnt         <= '0;
        end
        ST_NORM: begin
          out_data <= lane_res;
          out_lane <= cnt;
        end
        ST_SEND: if (out_ready && cnt != 2'(LANES - 1)) cnt <= cnt + 2'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fmab_norm.sv
// Randomized bench for fmab_norm against an arithmetic binary32 reference model.
// Honours FMAB_NORM_RNE_EN the same way as the design.
`timescale 1ns/1ps
module tb_fmab_norm;
  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic        busy, out_valid, done;
  logic [31:0] out_data;
  logic [1:0]  out_lane;
  logic [31:0] acc_v [4];
  logic [9:0]  exp_v [4];
  logic [31:0] got   [4];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fmab_norm dut (
    .clk(clk), .reset(reset), .start(start),
    .acc0(acc_v[0]), .acc1(acc_v[1]), .acc2(acc_v[2]), .acc3(acc_v[3]),
    .exp0(exp_v[0]), .exp1(exp_v[1]), .exp2(exp_v[2]), .exp3(exp_v[3]),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // value = acc * 2^(exp-268), rounded by integer quotient/remainder
  function automatic logic [31:0] ref_conv(input logic [31:0] a, input logic [9:0] e);
    longint mag, q;
    int     p, sh, ex;
    bit     s;
`ifdef FMAB_NORM_RNE_EN
    longint rem, half;
`endif
    if (a == 0 || e == 0) return 32'h0;
    s   = a[31];
    mag = s ? (64'd4294967296 - {32'd0, a}) : {32'd0, a};
    p   = 0;
    while ((mag >> (p + 1)) != 0) p++;
    ex  = p + int'(e) - 141;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh = p - 23;
      q  = mag >> sh;
`ifdef FMAB_NORM_RNE_EN
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
`endif
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        ex++;
      end
    end
    if (ex <= 0)   return {s, 31'b0};
    if (ex >= 255) return {s, 8'hFF, 23'b0};
    return {s, ex[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_acc();
    logic [31:0] a;
    a = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 7) == 0) a = 32'h80000000;
    else if ($urandom_range(0, 1) == 1) a = -a;
    return a;
  endfunction

  function automatic logic [9:0] rand_exp();
    if ($urandom_range(0, 1) == 1) return 10'($urandom_range(80, 420));
    return 10'($urandom_range(0, 1023));
  endfunction

  // Starts a batch, optionally stalls one lane, and checks every lane, latency and done.
  task automatic do_batch(input int stall_lane, input int stall_n);
    logic [31:0] exp_q [4];
    int  lane, stalled, first_acc, done_cyc, want_done;
    bit  acc_now;
    for (int i = 0; i < 4; i++) exp_q[i] = ref_conv(acc_v[i], exp_v[i]);
    want_done = 8 + ((stall_lane < 4) ? stall_n : 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      acc_v[i] = $urandom;
      exp_v[i] = 10'($urandom);
    end
    lane = 0; stalled = 0; first_acc = -1; done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      acc_now = 1'b0;
      start   = (c == 3);
      if (out_valid && lane < 4) begin
        if (first_acc < 0) first_acc = c;
        if (lane == stall_lane && stalled < stall_n) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          acc_now   = 1'b1;
        end
        check("lane_data", out_data, exp_q[lane]);
        check("lane_idx", 32'(out_lane), 32'(lane));
        if (acc_now) got[lane] = out_data;
      end else begin
        out_ready = 1'($urandom);
      end
      tick();
      if (acc_now) lane++;
      if (done) begin
        done_cyc = c;
        check("busy_at_done", 32'(busy), 32'd0);
        check("lanes_before_done", 32'(lane), 32'd4);
        break;
      end
    end
    start = 1'b0;
    check("first_accept_edge", 32'(first_acc), 32'd2);
    check("done_latency", 32'(done_cyc), 32'(want_done));
  endtask

  task automatic do_abort();
    bit saw_done;
    for (int i = 0; i < 4; i++) begin
      acc_v[i] = rand_acc();
      exp_v[i] = rand_exp();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !(out_valid && out_lane == 2'd2); c++) tick();
    check("abort_at_lane2", 32'(out_lane), 32'd2);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_data", out_data, 32'd0);
    saw_done = done;
    for (int c = 0; c < 10; c++) begin
      tick();
      saw_done |= done;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc_v[i] = '0;
      exp_v[i] = '0;
      got[i]   = '0;
    end
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_lane", 32'(out_lane), 32'd0);

    acc_v = '{32'h00004000, 32'hFFFFC000, 32'h00000000, 32'h00000005};
    exp_v = '{10'd254, 10'd255, 10'd300, 10'd0};
    do_batch(1, 5);
    check("vec_one", got[0], 32'h3F800000);
    check("vec_neg_two", got[1], 32'hC0000000);
    check("vec_acc_zero", got[2], 32'h00000000);
    check("vec_exp_zero", got[3], 32'h00000000);

    acc_v = '{32'h01FFFFFF, 32'h40000000, 32'h00000001, 32'h80000000};
    exp_v = '{10'd254, 10'd510, 10'd100, 10'd200};
    do_batch(4, 0);
`ifdef FMAB_NORM_RNE_EN
    check("vec_round", got[0], 32'h45000000);
`else
    check("vec_round", got[0], 32'h44FFFFFF);
`endif
    check("vec_overflow", got[1], 32'h7F800000);
    check("vec_underflow", got[2], 32'h00000000);
    check("vec_most_neg", got[3], 32'hAD000000);

    do_abort();

    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 4; i++) begin
        acc_v[i] = rand_acc();
        exp_v[i] = rand_exp();
      end
      do_batch(int'($urandom_range(0, 5)), int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
